shared_io_bus_ctrl: RTL and testbench

SHARED_IO_BUS_CTRL -- requirements
Module: shared_io_bus_ctrl

---
 rtl/shared_io_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_shared_io_bus_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shared_io_bus_ctrl.sv
// rtl/shared_io_bus_ctrl.sv - half-duplex shared I/O bus controller with output result FIFO
module shared_io_bus_ctrl #(
    parameter int IO_DATA_WIDTH     = 16,
    parameter int OUT_FIFO_DEPTH    = 8,
    parameter int TURNAROUND_CYCLES = 1,
    parameter int MAX_BURST         = 4,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic [IO_DATA_WIDTH-1:0] res_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic                     psum_req,
    output logic [IO_DATA_WIDTH-1:0] psum_data,
    output logic                     psum_valid,
    input  logic                     psum_ready,
    input  logic [IO_DATA_WIDTH-1:0] bus_data_i,
    output logic [IO_DATA_WIDTH-1:0] bus_data_o,
    output logic                     bus_oe,
    output logic                     bus_out_valid,
    input  logic                     bus_out_ready,
    input  logic                     bus_in_valid,
    output logic                     bus_in_ready,
    output logic [CNT_WIDTH-1:0]     words_out,
    output logic [CNT_WIDTH-1:0]     words_in
);

    localparam int PW = $clog2(OUT_FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] FULL_OCC  = OW'(OUT_FIFO_DEPTH);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [2:0]    TURN_LAST = 3'(TURNAROUND_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;
    localparam logic [1:0] S_RECV  = 2'd3;

    logic [IO_DATA_WIDTH-1:0] fifo_mem [OUT_FIFO_DEPTH];
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [OW-1:0]            occ, occ_next;
    logic [1:0]               state, state_next, target, target_next;
    logic                     last_drive;
    logic [2:0]               turn_cnt;
    logic [BW-1:0]            burst_cnt, burst_next;
    logic                     fifo_empty, fifo_full, push, pop, oe_q;
    logic [CNT_WIDTH-1:0]     out_cnt, in_cnt;

    assign fifo_empty    = (occ == '0);
    assign fifo_full     = (occ == FULL_OCC);
    assign res_ready     = !fifo_full;
    assign push          = res_valid && !fifo_full;
    assign bus_out_valid = (state == S_DRIVE) && !fifo_empty;
    assign pop           = bus_out_valid && bus_out_ready;
    assign bus_data_o    = (state == S_DRIVE) ? fifo_mem[rd_ptr] : '0;
    assign bus_oe        = oe_q;
    assign psum_valid    = (state == S_RECV) && bus_in_valid;
    assign psum_data     = (state == S_RECV) ? bus_data_i : '0;
    assign bus_in_ready  = (state == S_RECV) && psum_ready;
    assign words_out     = out_cnt;
    assign words_in      = in_cnt;

    always_comb begin
        occ_next = occ;
        if (push && !pop)
            occ_next = occ + OW'(1);
        else if (pop && !push)
            occ_next = occ - OW'(1);
    end

    // Burst count saturates so a long burst without psum_req cannot wrap
    always_comb begin
        burst_next = burst_cnt;
        if (pop && burst_cnt != BURST_MAX)
            burst_next = burst_cnt + BW'(1);
    end

    always_comb begin
        state_next  = state;
        target_next = target;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (!last_drive) begin
                        state_next  = S_TURN;
                        target_next = S_DRIVE;
                    end else begin
                        state_next = S_DRIVE;
                    end
                end else if (psum_req) begin
                    if (last_drive) begin
                        state_next  = S_TURN;
                        target_next = S_RECV;
                    end else begin
                        state_next = S_RECV;
                    end
                end
            end
            S_DRIVE: begin
                if (occ_next == '0) begin
                    state_next = S_IDLE;
                end else if (psum_req && burst_next == BURST_MAX) begin
                    state_next  = S_TURN;
                    target_next = S_RECV;
                end
            end
            S_TURN: begin
                if (turn_cnt == TURN_LAST)
                    state_next = target;
            end
            S_RECV: begin
                if (!psum_req) begin
                    state_next = S_IDLE;
                end else if (fifo_full) begin
                    state_next  = S_TURN;
                    target_next = S_DRIVE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= res_data;
    end

    // bus_oe is registered from the next state so it is exactly "state == DRIVE" without glitches
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= S_IDLE;
            target     <= S_IDLE;
            last_drive <= 1'b0;
            turn_cnt   <= '0;
            burst_cnt  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            oe_q       <= 1'b0;
            out_cnt    <= '0;
            in_cnt     <= '0;
        end else begin
            state  <= state_next;
            target <= target_next;
            oe_q   <= (state_next == S_DRIVE);
            if (state == S_DRIVE)
                last_drive <= 1'b1;
            else if (state == S_RECV)
                last_drive <= 1'b0;
            turn_cnt  <= (state == S_TURN && state_next == S_TURN) ? turn_cnt + 3'd1 : 3'd0;
            burst_cnt <= (state == S_DRIVE) ? burst_next : '0;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            occ <= occ_next;
            if (pop && out_cnt != '1)
                out_cnt <= out_cnt + CNT_WIDTH'(1);
            if (bus_in_valid && bus_in_ready && in_cnt != '1)
                in_cnt <= in_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_shared_io_bus_ctrl.sv
// tb/tb_shared_io_bus_ctrl.sv - directed self-checking bench for shared_io_bus_ctrl
module tb_shared_io_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_in;
    logic [15:0] res_data;
    logic        res_valid, psum_req, psum_ready, bus_out_ready, bus_in_valid;
    logic [15:0] bus_data_i;

    logic        a_res_ready, a_psum_valid, a_bus_oe, a_bus_out_valid, a_bus_in_ready;
    logic [15:0] a_psum_data, a_bus_data_o;
    logic [31:0] a_words_out, a_words_in;

    logic        b_res_ready, b_psum_valid, b_bus_oe, b_bus_out_valid, b_bus_in_ready;
    logic [15:0] b_psum_data, b_bus_data_o;
    logic [3:0]  b_words_out, b_words_in;

    int checks = 0;
    int errors = 0;

    shared_io_bus_ctrl u_dut_a (
        .clk(clk), .rst_in(rst_in), .res_data(res_data), .res_valid(res_valid),
        .res_ready(a_res_ready), .psum_req(psum_req), .psum_data(a_psum_data),
        .psum_valid(a_psum_valid), .psum_ready(psum_ready), .bus_data_i(bus_data_i),
        .bus_data_o(a_bus_data_o), .bus_oe(a_bus_oe), .bus_out_valid(a_bus_out_valid),
        .bus_out_ready(bus_out_ready), .bus_in_valid(bus_in_valid),
        .bus_in_ready(a_bus_in_ready), .words_out(a_words_out), .words_in(a_words_in)
    );

    shared_io_bus_ctrl #(.TURNAROUND_CYCLES(3), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst_in(rst_in), .res_data(res_data), .res_valid(res_valid),
        .res_ready(b_res_ready), .psum_req(psum_req), .psum_data(b_psum_data),
        .psum_valid(b_psum_valid), .psum_ready(psum_ready), .bus_data_i(bus_data_i),
        .bus_data_o(b_bus_data_o), .bus_oe(b_bus_oe), .bus_out_valid(b_bus_out_valid),
        .bus_out_ready(bus_out_ready), .bus_in_valid(bus_in_valid),
        .bus_in_ready(b_bus_in_ready), .words_out(b_words_out), .words_in(b_words_in)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_in = 1'b1; res_valid = 1'b0; res_data = '0; psum_req = 1'b0; psum_ready = 1'b0;
        bus_data_i = '0; bus_out_ready = 1'b0; bus_in_valid = 1'b0;
        step; step;
        rst_in = 1'b0;
    endtask

    task automatic push_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            res_valid = 1'b1; res_data = base + 16'(i);
            step;
        end
        res_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if ({a_bus_oe, a_bus_out_valid, a_bus_in_ready, a_psum_valid, a_res_ready} !== 5'b00001) begin errors++; $display("FAIL reset_a_ctrl got %b want 00001", {a_bus_oe, a_bus_out_valid, a_bus_in_ready, a_psum_valid, a_res_ready}); end
        checks++; if (a_bus_data_o !== 16'h0 || a_psum_data !== 16'h0) begin errors++; $display("FAIL reset_a_data got %h/%h want 0/0", a_bus_data_o, a_psum_data); end
        checks++; if (a_words_out !== 32'd0 || a_words_in !== 32'd0) begin errors++; $display("FAIL reset_a_cnt got %0d/%0d want 0/0", a_words_out, a_words_in); end
        checks++; if ({b_bus_oe, b_bus_out_valid, b_bus_in_ready, b_psum_valid, b_res_ready} !== 5'b00001) begin errors++; $display("FAIL reset_b_ctrl got %b want 00001", {b_bus_oe, b_bus_out_valid, b_bus_in_ready, b_psum_valid, b_res_ready}); end
        checks++; if (b_bus_data_o !== 16'h0 || b_psum_data !== 16'h0 || b_words_out !== 4'd0 || b_words_in !== 4'd0) begin errors++; $display("FAIL reset_b_data got %h/%h/%0d/%0d want 0", b_bus_data_o, b_psum_data, b_words_out, b_words_in); end
        psum_ready = 1'b1; bus_in_valid = 1'b1; bus_data_i = 16'h1234; #1;
        checks++; if (a_bus_in_ready !== 1'b0 || a_psum_valid !== 1'b0 || a_psum_data !== 16'h0) begin errors++; $display("FAIL idle_recv_gate got %b/%b/%h want 0/0/0", a_bus_in_ready, a_psum_valid, a_psum_data); end
        psum_ready = 1'b0; bus_in_valid = 1'b0; bus_data_i = '0;
    endtask

    task automatic test_drive_three;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033;
        do_reset;
        bus_out_ready = 1'b1;
        res_valid = 1'b1; res_data = exp_w[0]; step;
        res_data = exp_w[1]; step;
        checks++; if (a_bus_oe !== 1'b0 || a_bus_out_valid !== 1'b0) begin errors++; $display("FAIL drive3_turn got oe=%b v=%b want 0/0", a_bus_oe, a_bus_out_valid); end
        res_data = exp_w[2]; step;
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_bus_oe !== 1'b1 || a_bus_out_valid !== 1'b1 || a_bus_data_o !== exp_w[i]) begin errors++; $display("FAIL drive3_word%0d got oe=%b v=%b d=%h want 1/1/%h", i, a_bus_oe, a_bus_out_valid, a_bus_data_o, exp_w[i]); end
            step;
        end
        checks++; if (a_bus_oe !== 1'b0 || a_bus_out_valid !== 1'b0 || a_bus_data_o !== 16'h0) begin errors++; $display("FAIL drive3_idle got oe=%b v=%b d=%h want 0/0/0", a_bus_oe, a_bus_out_valid, a_bus_data_o); end
        checks++; if (a_words_out !== 32'd3) begin errors++; $display("FAIL drive3_words_out got %0d want 3", a_words_out); end
    endtask

    task automatic test_burst_yield;
        do_reset;
        push_words(16'h00A0, 8);
        checks++; if (a_res_ready !== 1'b0) begin errors++; $display("FAIL burst_full got res_ready=%b want 0", a_res_ready); end
        psum_req = 1'b1; bus_out_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_bus_oe !== 1'b1 || a_bus_out_valid !== 1'b1 || a_bus_data_o !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL burst_first%0d got oe=%b v=%b d=%h want 1/1/%h", i, a_bus_oe, a_bus_out_valid, a_bus_data_o, 16'h00A0 + 16'(i)); end
            step;
        end
        bus_data_i = 16'hBEEF; bus_in_valid = 1'b1; psum_ready = 1'b1; #1;
        checks++; if (a_bus_oe !== 1'b0 || a_bus_in_ready !== 1'b0 || a_psum_valid !== 1'b0) begin errors++; $display("FAIL burst_turn got oe=%b ir=%b pv=%b want 0/0/0", a_bus_oe, a_bus_in_ready, a_psum_valid); end
        step;
        checks++; if (a_bus_oe !== 1'b0 || a_bus_in_ready !== 1'b1 || a_psum_valid !== 1'b1 || a_psum_data !== 16'hBEEF) begin errors++; $display("FAIL burst_recv got oe=%b ir=%b pv=%b pd=%h want 0/1/1/beef", a_bus_oe, a_bus_in_ready, a_psum_valid, a_psum_data); end
        step;
        checks++; if (a_words_in !== 32'd1) begin errors++; $display("FAIL burst_words_in got %0d want 1", a_words_in); end
        bus_in_valid = 1'b0; psum_req = 1'b0;
        step; step;
        checks++; if (a_bus_oe !== 1'b0 || a_bus_in_ready !== 1'b0) begin errors++; $display("FAIL burst_turn_back got oe=%b ir=%b want 0/0", a_bus_oe, a_bus_in_ready); end
        step;
        for (int i = 4; i < 8; i++) begin
            checks++; if (a_bus_oe !== 1'b1 || a_bus_data_o !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL burst_rest%0d got oe=%b d=%h want 1/%h", i, a_bus_oe, a_bus_data_o, 16'h00A0 + 16'(i)); end
            step;
        end
        checks++; if (a_bus_oe !== 1'b0 || a_words_out !== 32'd8) begin errors++; $display("FAIL burst_done got oe=%b wo=%0d want 0/8", a_bus_oe, a_words_out); end
    endtask

    task automatic test_full_hold;
        do_reset;
        push_words(16'h00B0, 8);
        res_valid = 1'b1; res_data = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (a_res_ready !== 1'b0) begin errors++; $display("FAIL full_res_ready%0d got %b want 0", i, a_res_ready); end
        end
        res_valid = 1'b0; bus_out_ready = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (a_bus_out_valid !== 1'b1 || a_bus_data_o !== 16'h00B0 + 16'(i)) begin errors++; $display("FAIL full_drain%0d got v=%b d=%h want 1/%h", i, a_bus_out_valid, a_bus_data_o, 16'h00B0 + 16'(i)); end
            step;
        end
        checks++; if (a_bus_out_valid !== 1'b0 || a_words_out !== 32'd8 || a_res_ready !== 1'b1) begin errors++; $display("FAIL full_after got v=%b wo=%0d rr=%b want 0/8/1", a_bus_out_valid, a_words_out, a_res_ready); end
    endtask

    task automatic test_turnaround3;
        do_reset;
        push_words(16'h00C0, 5);
        checks++; if (b_bus_oe !== 1'b1 || b_bus_data_o !== 16'h00C0) begin errors++; $display("FAIL turn3_drive got oe=%b d=%h want 1/00c0", b_bus_oe, b_bus_data_o); end
        psum_req = 1'b1; bus_out_ready = 1'b1; psum_ready = 1'b1;
        for (int i = 0; i < 4; i++) step;
        for (int i = 0; i < 3; i++) begin
            checks++; if (b_bus_oe !== 1'b0 || b_bus_in_ready !== 1'b0) begin errors++; $display("FAIL turn3_gap%0d got oe=%b ir=%b want 0/0", i, b_bus_oe, b_bus_in_ready); end
            step;
        end
        checks++; if (b_bus_oe !== 1'b0 || b_bus_in_ready !== 1'b1) begin errors++; $display("FAIL turn3_recv got oe=%b ir=%b want 0/1", b_bus_oe, b_bus_in_ready); end
        psum_ready = 1'b0; #1;
        checks++; if (b_bus_in_ready !== 1'b0) begin errors++; $display("FAIL turn3_follow got ir=%b want 0", b_bus_in_ready); end
    endtask

    task automatic test_saturate;
        do_reset;
        bus_out_ready = 1'b1;
        push_words(16'h0000, 20);
        for (int i = 0; i < 30; i++) step;
        checks++; if (b_words_out !== 4'hF) begin errors++; $display("FAIL sat_b_words_out got %0d want 15", b_words_out); end
        checks++; if (a_words_out !== 32'd20) begin errors++; $display("FAIL sat_a_words_out got %0d want 20", a_words_out); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        push_words(16'h00D0, 6);
        bus_out_ready = 1'b1; step; bus_out_ready = 1'b0;
        checks++; if (a_bus_oe !== 1'b1 || a_words_out !== 32'd1 || a_bus_data_o !== 16'h00D1) begin errors++; $display("FAIL rmid_pre got oe=%b wo=%0d d=%h want 1/1/00d1", a_bus_oe, a_words_out, a_bus_data_o); end
        rst_in = 1'b1; step;
        checks++; if (a_bus_oe !== 1'b0 || a_res_ready !== 1'b1 || a_words_out !== 32'd0 || b_bus_oe !== 1'b0) begin errors++; $display("FAIL rmid_edge got oe=%b rr=%b wo=%0d boe=%b want 0/1/0/0", a_bus_oe, a_res_ready, a_words_out, b_bus_oe); end
        rst_in = 1'b0; bus_out_ready = 1'b1;
        step; step; step;
        checks++; if (a_bus_oe !== 1'b0 || a_bus_out_valid !== 1'b0 || a_words_out !== 32'd0 || a_bus_data_o !== 16'h0) begin errors++; $display("FAIL rmid_empty got oe=%b v=%b wo=%0d d=%h want 0/0/0/0", a_bus_oe, a_bus_out_valid, a_words_out, a_bus_data_o); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_drive_three;
        test_burst_yield;
        test_full_hold;
        test_turnaround3;
        test_saturate;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
